// File: rtl/aes_axis_pkt_tx.sv
// AXI-Stream packet transmitter: one command beat followed by N 128-bit blocks
// fetched from a local block RAM and sent as four 32-bit beats each, MSW first.
module aes_axis_pkt_tx #(
    parameter int ADDR_WIDTH           = 9,
    parameter int DEPTH                = 512,
    parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                  m00_axis_aclk,
    input  logic                  m00_axis_aresetn,
    input  logic                  start,
    input  logic [31:0]           cmd,
    input  logic [ADDR_WIDTH-1:0] blk_cnt_m1,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [127:0]          rd_data,
    output logic                  m00_axis_tvalid,
    output logic [31:0]           m00_axis_tdata,
    output logic [3:0]            m00_axis_tstrb,
    output logic                  m00_axis_tlast,
    input  logic                  m00_axis_tready,
    output logic                  busy,
    output logic                  done
);

    // state          | meaning
    // S_IDLE         | waiting for start; issues the block 0 read on accept
    // S_SEND_CMD     | command beat presented; cur_blk tracks block 0 read data
    // S_SEND_PAYLOAD | streaming block words; prefetches the next block
    // S_FINISH       | one-cycle done pulse, then back to idle
    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_CMD,
        S_SEND_PAYLOAD,
        S_FINISH
    } state_e;

    if (DEPTH != (1 << ADDR_WIDTH) || C_M_AXIS_TDATA_WIDTH != 32) begin : g_param_err
        $error("aes_axis_pkt_tx: DEPTH must be 2**ADDR_WIDTH and stream width must be 32");
    end

    state_e                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] cnt_q,      cnt_d;
    logic [ADDR_WIDTH-1:0] blk_idx_q,  blk_idx_d;
    logic [1:0]            word_idx_q, word_idx_d;
    logic [127:0]          cur_blk_q,  cur_blk_d;
    logic                  pf_q,       pf_d;
    logic                  tvalid_q,   tvalid_d;
    logic [31:0]           tdata_q,    tdata_d;
    logic                  tlast_q,    tlast_d;

    logic                  hs;
    logic [ADDR_WIDTH-1:0] blk_nxt;
    logic [1:0]            word_nxt;

    function automatic logic [31:0] sel_word(input logic [127:0] blk, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    assign hs       = tvalid_q & m00_axis_tready;
    assign blk_nxt  = blk_idx_q + ADDR_WIDTH'(1);
    assign word_nxt = word_idx_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blk_idx_d  = blk_idx_q;
        word_idx_d = word_idx_q;
        cur_blk_d  = cur_blk_q;
        pf_d       = pf_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        rd_en      = 1'b0;
        rd_addr    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d      = blk_cnt_m1;
                    rd_en      = 1'b1;
                    rd_addr    = '0;
                    tvalid_d   = 1'b1;
                    tdata_d    = cmd;
                    tlast_d    = 1'b0;
                    blk_idx_d  = '0;
                    word_idx_d = 2'd0;
                    pf_d       = 1'b0;
                    state_d    = S_SEND_CMD;
                end
            end
            S_SEND_CMD: begin
                // RAM output holds while rd_en is low, so tracking it every cycle is safe
                cur_blk_d = rd_data;
                if (hs) begin
                    tdata_d    = rd_data[127:96];
                    tlast_d    = 1'b0;
                    word_idx_d = 2'd0;
                    blk_idx_d  = '0;
                    pf_d       = (cnt_q != '0);
                    state_d    = S_SEND_PAYLOAD;
                end
            end
            S_SEND_PAYLOAD: begin
                if (pf_q) begin
                    rd_en   = 1'b1;
                    rd_addr = blk_nxt;
                    pf_d    = 1'b0;
                end
                if (hs) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = S_FINISH;
                    end else if (word_idx_q == 2'd3) begin
                        // prefetched block has been waiting on rd_data for >= 3 cycles
                        cur_blk_d  = rd_data;
                        blk_idx_d  = blk_nxt;
                        word_idx_d = 2'd0;
                        tdata_d    = rd_data[127:96];
                        tlast_d    = 1'b0;
                        pf_d       = (blk_nxt != cnt_q);
                    end else begin
                        word_idx_d = word_nxt;
                        tdata_d    = sel_word(cur_blk_q, word_nxt);
                        tlast_d    = (word_nxt == 2'd3) && (blk_idx_q == cnt_q);
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            blk_idx_q  <= '0;
            word_idx_q <= 2'd0;
            cur_blk_q  <= '0;
            pf_q       <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blk_idx_q  <= blk_idx_d;
            word_idx_q <= word_idx_d;
            cur_blk_q  <= cur_blk_d;
            pf_q       <= pf_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
        end
    end

    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tstrb  = 4'hF;
    assign busy            = (state_q == S_SEND_CMD) || (state_q == S_SEND_PAYLOAD);
    assign done            = (state_q == S_FINISH);

endmodule

// File: tb/tb_aes_axis_pkt_tx.sv
// Scoreboard bench for aes_axis_pkt_tx: directed packets with a block RAM model,
// expected beats/addresses/done queued at issue and checked by a negedge monitor.
module tb_aes_axis_pkt_tx;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          c;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [31:0]  cmd;
    logic [8:0]   cnt;
    logic         rd_en;
    logic [8:0]   rd_addr;
    logic [127:0] rd_data;
    logic         tvalid;
    logic [31:0]  tdata;
    logic [3:0]   tstrb;
    logic         tlast;
    logic         tready = 1'b0;
    logic         busy;
    logic         done;

    logic [127:0] mem [0:511];

    beat_t    exp_q[$];
    int       addr_q[$];
    int       done_q[$];
    bit       rdy_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    aes_axis_pkt_tx #(.ADDR_WIDTH(9), .DEPTH(512), .C_M_AXIS_TDATA_WIDTH(32)) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_aresetn(rst_n),
        .start           (start),
        .cmd             (cmd),
        .blk_cnt_m1      (cnt),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tdata  (tdata),
        .m00_axis_tstrb  (tstrb),
        .m00_axis_tlast  (tlast),
        .m00_axis_tready (tready),
        .busy            (busy),
        .done            (done)
    );

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    end

    // monitor
    bit          stall_pend = 0;
    logic [31:0] held_d;
    logic        held_l;
    beat_t       e;
    int          ea;
    int          ed;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid) begin
                if (stall_pend) begin
                    chk("stall_tdata", tdata, held_d);
                    chk("stall_tlast", tlast, held_l);
                end
                if (tready) begin
                    stall_pend = 0;
                    if (exp_q.size() == 0) fail("unexpected_beat");
                    else begin
                        e = exp_q.pop_front();
                        chk("beat_data", tdata, e.d);
                        chk("beat_last", tlast, e.l);
                        chk("beat_strb", tstrb, 4'hF);
                        if (e.c >= 0) begin
                            chk("beat_cycle", cyc - start_cyc, e.c);
                            chk("busy_during", busy, 1'b1);
                        end
                    end
                end else begin
                    stall_pend = 1;
                    held_d = tdata;
                    held_l = tlast;
                end
            end else if (stall_pend) begin
                fail("tvalid_dropped");
                stall_pend = 0;
            end
            if (rd_en) begin
                if (addr_q.size() == 0) fail("unexpected_rd");
                else begin
                    ea = addr_q.pop_front();
                    chk("rd_addr", rd_addr, ea);
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 1'b0);
                if (done_q.size() == 0) fail("unexpected_done");
                else begin
                    ed = done_q.pop_front();
                    if (ed >= 0) chk("done_cycle", cyc - start_cyc, ed);
                end
            end
        end else begin
            stall_pend = 0;
        end
    end

    task automatic push_pkt(input logic [31:0] c, input logic [8:0] n, input bit timed);
        beat_t b;
        b.d = c; b.l = 1'b0; b.c = timed ? 1 : -1;
        exp_q.push_back(b);
        for (int k = 0; k <= int'(n); k++) begin
            addr_q.push_back(k);
            for (int w = 0; w < 4; w++) begin
                b.d = mem[k][127-32*w -: 32];
                b.l = (k == int'(n)) && (w == 3);
                b.c = timed ? (2 + 4*k + w) : -1;
                exp_q.push_back(b);
            end
        end
        done_q.push_back(timed ? (4*(int'(n)+1) + 2) : -1);
    endtask

    task automatic start_pkt(input logic [31:0] c, input logic [8:0] n);
        @(posedge clk);
        #1;
        start = 1'b1;
        cmd = c;
        cnt = n;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        cmd = ~c;
        cnt = ~n;
    endtask

    task automatic run_pkt(input logic [31:0] c, input logic [8:0] n, input bit timed, input bit bp);
        int d0;
        push_pkt(c, n, timed);
        d0 = done_cnt;
        start_pkt(c, n);
        if (bp) rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5000 && done_cnt == d0; i++) @(posedge clk);
        if (done_cnt == d0) fail("done_timeout");
        repeat (2) @(posedge clk);
        #1;
        chk("beats_left", exp_q.size(), 0);
        chk("addrs_left", addr_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        mem[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        for (int i = 1; i < 512; i++)
            mem[i] = {32'h1000_0000 + i, 32'h2000_0000 + i, 32'h3000_0000 + i, 32'h4000_0000 + i};
        start = 1'b0; cmd = '0; cnt = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_rd_addr", rd_addr, 9'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_pkt(32'h0000_0001, 9'd0, 1'b1, 1'b0);
        run_pkt(32'h0000_0001, 9'd0, 1'b0, 1'b1);
        run_pkt(32'hA5A5_0003, 9'd2, 1'b1, 1'b0);

        fork
            run_pkt(32'h0000_0042, 9'd1, 1'b1, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1;
                start = 1'b1; cmd = 32'hDEAD_BEEF; cnt = 9'd5;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        run_pkt(32'hCAFE_0002, 9'd0, 1'b1, 1'b0);

        push_pkt(32'h0000_0009, 9'd1, 1'b1);
        start_pkt(32'h0000_0009, 9'd1);
        @(posedge clk);
        @(posedge clk);
        #7;
        chk("pre_rst_beats_left", exp_q.size(), 6);
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", tvalid, 1'b0);
        chk("midrst_tlast", tlast, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rd_en", rd_en, 1'b0);
        exp_q.delete();
        addr_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        d0 = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_cnt, d0);
        run_pkt(32'h1234_5678, 9'd1, 1'b1, 1'b0);

        run_pkt(32'h0000_01FF, 9'd511, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
